// File: rtl/pc_update_unit_pkg.sv
// Shared definitions for the PC update stage: run/halt/trap state encoding,
// the sequential PC increment and the ECALL halt code compared against x17.
package pc_update_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_e;

  // Byte distance between consecutive 32-bit instructions.
  localparam logic [31:0] PC_INC = 32'd4;

  // Value of x17 (a7) that turns an ECALL into a simulation halt request.
  localparam logic [31:0] HALT_ECALL_X17 = 32'd10;

  // True when an address is a legal 4-byte instruction address.
  function automatic logic pc_is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage : pc_update_unit_pkg

// File: rtl/pc_update_unit_next_pc_sel.sv
// Combinational next-PC selection: JALR target, PC-relative jump/branch
// target, or sequential PC+4. All arithmetic is 32-bit modulo.
module pc_update_unit_next_pc_sel
  import pc_update_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        alu_bcond,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  logic [31:0] rel_target_s;
  logic [31:0] seq_target_s;
  logic        take_rel_s;

  // Both adders are always evaluated; the mux below picks one.
  always_comb begin
    seq_target_s = pc + PC_INC;
    rel_target_s = pc + imm;
    take_rel_s   = jal | (branch & alu_bcond);
  end

  // Priority select: JALR over JAL/taken branch over fall-through.
  // JALR clears bit 0 of the computed address as RV32I requires.
  always_comb begin
    target = seq_target_s;
    if (jalr) begin
      target = alu_result & ~32'h0000_0001;
    end else if (take_rel_s) begin
      target = rel_target_s;
    end else begin
      target = seq_target_s;
    end
  end

  // Link value for JAL/JALR writeback.
  always_comb begin
    pc_plus4 = seq_target_s;
  end

endmodule : pc_update_unit_next_pc_sel

// File: rtl/pc_update_unit.sv
// Program-counter stage of the single-cycle RV32I core.
// Holds the PC register, the RUN/HALT/TRAP state machine and a saturating
// retired-instruction counter.
// Optional build macro: PC_MISALIGN_TRAP_EN -- when defined, a selected
// target that is not 4-byte aligned parks the core in TRAP instead of
// being loaded into the PC.
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic             alu_bcond,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      imm,
  input  logic             is_ecall,
  input  logic             halt_cond,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             is_halted,
  output logic             misaligned,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_halted_q, is_halted_d;
  logic             misaligned_q, misaligned_d;

  logic [31:0]      target_s;
  logic             advance_s;
  logic             halt_hit_s;
  logic             misalign_hit_s;
  logic             retire_s;

  pc_update_unit_next_pc_sel u_next_pc_sel (
    .pc         (pc_q),
    .imm        (imm),
    .alu_result (alu_result),
    .branch     (branch),
    .jal        (jal),
    .jalr       (jalr),
    .alu_bcond  (alu_bcond),
    .target     (target_s),
    .pc_plus4   (pc_plus4)
  );

  // Event decode: only a RUN cycle with pc_write can retire, halt or trap.
  always_comb begin
    advance_s  = (state_q == ST_RUN) & pc_write;
    halt_hit_s = advance_s & is_ecall & halt_cond;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_hit_s = advance_s & ~pc_is_aligned(target_s);
`else
    misalign_hit_s = 1'b0;
`endif
    // A halting ECALL retires even if its fall-through target is odd.
    retire_s = advance_s & (halt_hit_s | ~misalign_hit_s);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HALT has priority over TRAP; both are sticky.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_hit_s) begin
          state_d = ST_HALT;
        end else if (misalign_hit_s) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
`ifdef PC_MISALIGN_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs, decoded from the next state so the flags are registered.
  always_comb begin
    is_halted_d = (state_d == ST_HALT);
`ifdef PC_MISALIGN_TRAP_EN
    misaligned_d = (state_d == ST_TRAP);
`else
    misaligned_d = 1'b0;
`endif
  end

  // Next PC: halting or trapping instructions keep their own address.
  always_comb begin
    pc_d = pc_q;
    if (halt_hit_s || misalign_hit_s) begin
      pc_d = pc_q;
    end else if (advance_s) begin
      pc_d = target_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Retired-instruction counter, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (retire_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      is_halted_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      is_halted_q  <= is_halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Output drive.
  always_comb begin
    pc           = pc_q;
    retire_count = cnt_q;
    is_halted    = is_halted_q;
    misaligned   = misaligned_q;
  end

endmodule : pc_update_unit

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed scenarios followed by
// randomized stimulus compared against a behavioural reference model.
module tb_pc_update_unit;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pc_write;
  logic          branch;
  logic          jal;
  logic          jalr;
  logic          alu_bcond;
  logic [31:0]   alu_result;
  logic [31:0]   imm;
  logic          is_ecall;
  logic          halt_cond;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          is_halted;
  logic          misaligned;
  logic [CW-1:0] retire_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_halted;
  bit          m_trapped;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  pc_update_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_write     (pc_write),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .alu_bcond    (alu_bcond),
    .alu_result   (alu_result),
    .imm          (imm),
    .is_ecall     (is_ecall),
    .halt_cond    (halt_cond),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .is_halted    (is_halted),
    .misaligned   (misaligned),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit pw, input bit br, input bit j, input bit jr, input bit bc,
                       input logic [31:0] alu, input logic [31:0] im, input bit ec, input bit hc);
    pc_write = pw; branch = br; jal = j; jalr = jr; alu_bcond = bc;
    alu_result = alu; imm = im; is_ecall = ec; halt_cond = hc;
  endtask

  // One clock: predict from the architectural rules, clock the DUT, compare.
  task automatic tick();
    logic [31:0] tgt;
    #1;
    if (!reset) check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    if (reset) begin
      m_pc = 32'h0; m_cnt = 0; m_halted = 1'b0; m_trapped = 1'b0;
    end else if (!m_halted && !m_trapped && pc_write) begin
      if (jalr)                         tgt = {alu_result[31:1], 1'b0};
      else if (jal || (branch && alu_bcond)) tgt = m_pc + imm;
      else                              tgt = m_pc + 32'd4;
      if (is_ecall && halt_cond) begin
        m_halted = 1'b1;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (TRAP_EN && (tgt % 4 != 0)) begin
        m_trapped = 1'b1;
      end else begin
        m_pc = tgt;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
    @(posedge clk);
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("retire_count", {24'h0, retire_count}, m_cnt[31:0]);
    check_eq("is_halted", {31'h0, is_halted}, {31'h0, m_halted});
    check_eq("misaligned", {31'h0, misaligned}, {31'h0, m_trapped});
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); tick();
    check_eq("reset_pc", pc, 32'h0);
    check_eq("reset_cnt", {24'h0, retire_count}, 32'd0);
    reset = 1'b0;

    // Sequential fetch
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); check_eq("seq_pc1", pc, 32'h4);
    tick(); check_eq("seq_pc2", pc, 32'h8);
    tick(); check_eq("seq_pc3", pc, 32'hC);
    check_eq("seq_cnt", {24'h0, retire_count}, 32'd3);

    // Branch taken / not taken from 0x40
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h34, 1'b0, 1'b0); tick();
    check_eq("to_40", pc, 32'h40);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0); tick();
    check_eq("br_taken", pc, 32'h30);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0); tick();
    check_eq("br_not_taken", pc, 32'h44);

    // JALR beats JAL, bit 0 cleared
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0105, 32'h100, 1'b0, 1'b0);
    #1 check_eq("link_pc_plus4", pc_plus4, 32'h48);
    tick();
    check_eq("jalr_prio", pc, 32'h104);

    // Stall with jal pending
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h8, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("stall_pc", pc, 32'h104);
    check_eq("stall_cnt", {24'h0, retire_count}, 32'd8);
    pc_write = 1'b1; tick();
    check_eq("after_stall", pc, 32'h10C);

    // Halt at 0x80
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FF74, 1'b0, 1'b0); tick();
    check_eq("to_80", pc, 32'h80);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1); tick();
    check_eq("halt_flag", {31'h0, is_halted}, 32'd1);
    check_eq("halt_pc", pc, 32'h80);
    check_eq("halt_cnt", {24'h0, retire_count}, 32'd11);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 1'b0, 1'b0);
    tick(); tick(); tick();
    check_eq("halt_frozen", pc, 32'h80);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("rst_from_halt", {31'h0, is_halted}, 32'd0);

    // Misaligned JAL target
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h6, 1'b0, 1'b0); tick();
    check_eq("mis_pc", pc, TRAP_EN ? 32'h0 : 32'h6);
    check_eq("mis_flag", {31'h0, misaligned}, {31'h0, TRAP_EN});
    reset = 1'b1; tick(); reset = 1'b0;

    // Counter saturation
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 270; i++) tick();
    check_eq("cnt_sat", {24'h0, retire_count}, 32'd255);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      pc_write   = ($urandom_range(0, 3) != 0);
      branch     = $urandom_range(0, 1);
      jal        = ($urandom_range(0, 3) == 0);
      jalr       = ($urandom_range(0, 5) == 0);
      alu_bcond  = $urandom_range(0, 1);
      alu_result = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD);
      imm        = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h0000_0FFC) - 32'h800;
      is_ecall   = ($urandom_range(0, 15) == 0);
      halt_cond  = $urandom_range(0, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc_update_unit
